band_gain_interp: RTL and testbench

- Downstream of the output dense layer (22 sigmoid band gains).
- Expands the 22 band gains into 481 per-bin spectral gains by linear interpolation across the band edges.
- Streams one bin gain per cycle to the spectral gain-apply stage using a valid/ready handshake.
- Time-multiplexed: one input frame is captured, then 481 beats are emitted.

---
 rtl/band_gain_interp.sv | 229 ++++++++++++++++++++++
 tb/tb_band_gain_interp.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_gain_interp.sv
// Band gain interpolator: expands 22 band gains into 481 per-bin gains,
// streamed one bin per beat over a valid/ready handshake.
module band_gain_interp #(
    parameter int GW        = 16,
    parameter int NB_BANDS  = 22,
    parameter int FREQ_SIZE = 481
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB_BANDS*GW-1:0] gains_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [GW-1:0]          out_gain,
    output logic [8:0]             out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int NW = GW + 8;
    localparam logic [8:0] LAST_BIN = 9'(FREQ_SIZE - 1);
    localparam logic [8:0] TAIL_BIN = 9'd400;
    localparam logic [8:0] PRE_TAIL = 9'd399;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INTERP = 2'd1;
    localparam logic [1:0] S_TAIL   = 2'd2;

    // Band edges in units of 4 bins; entries past 21 clamp to the top edge.
    function automatic logic [6:0] band_edge(input logic [4:0] i);
        logic [6:0] e;
        case (i)
            5'd0:    e = 7'd0;
            5'd1:    e = 7'd1;
            5'd2:    e = 7'd2;
            5'd3:    e = 7'd3;
            5'd4:    e = 7'd4;
            5'd5:    e = 7'd5;
            5'd6:    e = 7'd6;
            5'd7:    e = 7'd7;
            5'd8:    e = 7'd8;
            5'd9:    e = 7'd10;
            5'd10:   e = 7'd12;
            5'd11:   e = 7'd14;
            5'd12:   e = 7'd16;
            5'd13:   e = 7'd20;
            5'd14:   e = 7'd24;
            5'd15:   e = 7'd28;
            5'd16:   e = 7'd34;
            5'd17:   e = 7'd40;
            5'd18:   e = 7'd48;
            5'd19:   e = 7'd60;
            5'd20:   e = 7'd78;
            default: e = 7'd100;
        endcase
        return e;
    endfunction

    function automatic logic [6:0] band_width(input logic [4:0] i);
        logic [6:0] d;
        d = band_edge(i + 5'd1) - band_edge(i);
        return {d[4:0], 2'b00};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] gains_q [NB_BANDS];

    logic          gen_busy_q, gen_busy_d;
    logic [8:0]    gen_bin_q, gen_bin_d;
    logic [4:0]    gen_band_q, gen_band_d;
    logic [6:0]    gen_j_q, gen_j_d;

    logic          s1_valid_q, s1_valid_d;
    logic [NW-1:0] s1_num_q, s1_num_d;
    logic [6:0]    s1_den_q, s1_den_d;
    logic [8:0]    s1_bin_q, s1_bin_d;
    logic          s1_last_q, s1_last_d;

    logic          out_valid_q, out_valid_d;
    logic [GW-1:0] out_gain_q, out_gain_d;
    logic [8:0]    out_index_q, out_index_d;
    logic          out_last_q, out_last_d;

    logic          accept;
    logic          out_fire;
    logic          out_adv;
    logic          s1_adv;
    logic          gen_fire;
    logic [4:0]    band_c;
    logic [GW-1:0] ga;
    logic [GW-1:0] gb;
    logic [6:0]    n_w;
    logic          in_interp;
    logic [NW-1:0] num;
    logic [NW-1:0] quot;

    assign in_ready  = (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign out_adv   = !out_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || out_adv;
    assign gen_fire  = gen_busy_q && s1_adv;

    assign out_valid = out_valid_q;
    assign out_gain  = out_gain_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

    // Numerator for the bin the generator is about to issue.
    always_comb begin
        band_c    = (gen_band_q > 5'd20) ? 5'd20 : gen_band_q;
        ga        = gains_q[band_c];
        gb        = gains_q[band_c + 5'd1];
        n_w       = band_width(band_c);
        in_interp = (gen_bin_q < TAIL_BIN);
        num       = NW'(ga) * NW'(n_w - gen_j_q)
                  + NW'(gb) * NW'(gen_j_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_INTERP;
            S_INTERP: if (out_fire && out_index_q == PRE_TAIL) state_d = S_TAIL;
            S_TAIL:   if (out_fire && out_last_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gen_busy_d = gen_busy_q;
        gen_bin_d  = gen_bin_q;
        gen_band_d = gen_band_q;
        gen_j_d    = gen_j_q;
        if (accept) begin
            gen_busy_d = 1'b1;
            gen_bin_d  = '0;
            gen_band_d = '0;
            gen_j_d    = '0;
        end else if (gen_fire) begin
            gen_bin_d  = gen_bin_q + 9'd1;
            gen_busy_d = (gen_bin_q != LAST_BIN);
            if (in_interp) begin
                if (gen_j_q == n_w - 7'd1) begin
                    gen_j_d    = '0;
                    gen_band_d = gen_band_q + 5'd1;
                end else begin
                    gen_j_d = gen_j_q + 7'd1;
                end
            end
        end
    end

    // Tail bins divide zero by one so the output stage needs no special case.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_num_d   = s1_num_q;
        s1_den_d   = s1_den_q;
        s1_bin_d   = s1_bin_q;
        s1_last_d  = s1_last_q;
        if (s1_adv) begin
            s1_valid_d = gen_fire;
            if (gen_fire) begin
                s1_num_d  = in_interp ? num : '0;
                s1_den_d  = in_interp ? n_w : 7'd1;
                s1_bin_d  = gen_bin_q;
                s1_last_d = (gen_bin_q == LAST_BIN);
            end
        end
    end

    always_comb begin
        quot        = s1_num_q / NW'(s1_den_q);
        out_valid_d = out_valid_q;
        out_gain_d  = out_gain_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_gain_d  = GW'(quot);
                out_index_d = s1_bin_q;
                out_last_d  = s1_last_q;
            end else begin
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gen_busy_q  <= 1'b0;
            gen_bin_q   <= '0;
            gen_band_q  <= '0;
            gen_j_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_num_q    <= '0;
            s1_den_q    <= 7'd1;
            s1_bin_q    <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_gain_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < NB_BANDS; k++) gains_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            gen_busy_q  <= gen_busy_d;
            gen_bin_q   <= gen_bin_d;
            gen_band_q  <= gen_band_d;
            gen_j_q     <= gen_j_d;
            s1_valid_q  <= s1_valid_d;
            s1_num_q    <= s1_num_d;
            s1_den_q    <= s1_den_d;
            s1_bin_q    <= s1_bin_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_gain_q  <= out_gain_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            if (accept) begin
                for (int k = 0; k < NB_BANDS; k++)
                    gains_q[k] <= gains_in[k*GW +: GW];
            end
        end
    end

endmodule

// File: tb/tb_band_gain_interp.sv
// Directed/randomised bench for band_gain_interp against a
// floor-division reference model.
module tb_band_gain_interp;

    localparam int GW = 16;
    localparam int NB = 22;
    localparam int FS = 481;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NB*GW-1:0] gains_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [GW-1:0]    out_gain;
    logic [8:0]       out_index;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;

    always #5 clk = ~clk;

    band_gain_interp dut (
        .clk       (clk),
        .rst       (rst),
        .gains_in  (gains_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_gain  (out_gain),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int E_TAB [22] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12,
                       14, 16, 20, 24, 28, 34, 40, 48, 60, 78, 100};

    logic [15:0] ref_g    [NB];
    logic [15:0] cap_gain [FS];
    logic [8:0]  cap_idx  [FS];
    logic        cap_last [FS];
    logic [15:0] save_gain[FS];
    int          cap_n, stall_viol, first_valid, timed_out;
    int          bad_k;
    logic        send_ready, post_ready, post_valid, busy_ready;

    function automatic int ref_gain(input int bin);
        int     i, n, j;
        longint num;
        if (bin >= 400) return 0;
        i = 0;
        while (4 * E_TAB[i+1] <= bin) i++;
        n   = 4 * (E_TAB[i+1] - E_TAB[i]);
        j   = bin - 4 * E_TAB[i];
        num = longint'(ref_g[i]) * (n - j) + longint'(ref_g[i+1]) * j;
        return int'(num / n);
    endfunction

    function automatic int frame_errs();
        int e;
        e = 0;
        bad_k = -1;
        for (int k = 0; k < FS && k < cap_n; k++) begin
            if (cap_gain[k] !== 16'(ref_gain(k)) || cap_idx[k] !== 9'(k)
                || cap_last[k] !== (k == FS - 1)) begin
                if (bad_k < 0) bad_k = k;
                e++;
            end
        end
        return e;
    endfunction

    task automatic send_frame();
        @(negedge clk);
        for (int k = 0; k < NB; k++) gains_in[k*GW +: GW] = ref_g[k];
        in_valid   = 1'b1;
        send_ready = in_ready;
    endtask

    task automatic collect(input bit rnd, input bit poke);
        logic [15:0] pg;
        logic [8:0]  pi;
        logic        pl;
        bit          held;
        cap_n = 0; stall_viol = 0; first_valid = -1; timed_out = 1;
        held = 0; pg = '0; pi = '0; pl = 1'b0; busy_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 0) in_valid = 1'b0;
            if (poke && c == 100) begin
                in_valid   = 1'b1;
                gains_in   = ~gains_in;
                busy_ready = in_ready;
            end
            if (poke && c == 106) in_valid = 1'b0;
            if (held && (out_valid !== 1'b1 || out_gain !== pg
                         || out_index !== pi || out_last !== pl))
                stall_viol++;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    if (cap_n < FS) begin
                        cap_gain[cap_n] = out_gain;
                        cap_idx[cap_n]  = out_index;
                        cap_last[cap_n] = out_last;
                    end
                    cap_n++;
                    if (out_last === 1'b1) begin
                        timed_out = 0;
                        break;
                    end
                end else begin
                    held = 1; pg = out_gain; pi = out_index; pl = out_last;
                end
            end
        end
        @(negedge clk);
        post_ready = in_ready;
        post_valid = out_valid;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        tests_run++;
        if (out_gain !== 16'h0 || out_index !== 9'd0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: gain=%h idx=%0d last=%b, want 0/0/0",
                     out_gain, out_index, out_last);
        end
    endtask

    task automatic test_unity();
        for (int k = 0; k < NB; k++) ref_g[k] = 16'h8000;
        send_frame();
        collect(1'b0, 1'b0);
        tests_run++;
        if (send_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL unity_accept: in_ready=%b, want 1", send_ready);
        end
        tests_run++;
        if (first_valid !== 2) begin
            tests_failed++;
            $display("FAIL unity_latency: first valid after %0d edges, want 2", first_valid);
        end
        tests_run++;
        if (timed_out != 0 || cap_n != FS) begin
            tests_failed++;
            $display("FAIL unity_count: beats=%0d timeout=%0d, want 481/0", cap_n, timed_out);
        end
        tests_run++;
        if (cap_gain[0] !== 16'h8000 || cap_gain[399] !== 16'h8000 || cap_gain[400] !== 16'h0
            || cap_gain[480] !== 16'h0) begin
            tests_failed++;
            $display("FAIL unity_edges: g0=%h g399=%h g400=%h g480=%h, want 8000/8000/0/0",
                     cap_gain[0], cap_gain[399], cap_gain[400], cap_gain[480]);
        end
        tests_run++;
        if (frame_errs() != 0) begin
            tests_failed++;
            $display("FAIL unity_frame: first bad bin %0d gain=%h idx=%0d last=%b, want gain=%h",
                     bad_k, cap_gain[bad_k], cap_idx[bad_k], cap_last[bad_k], ref_gain(bad_k));
        end
        tests_run++;
        if (post_ready !== 1'b1 || post_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL unity_idle: in_ready=%b out_valid=%b, want 1/0", post_ready, post_valid);
        end
    endtask

    task automatic test_ramp();
        for (int k = 0; k < NB; k++) ref_g[k] = 16'h0;
        ref_g[20] = 16'h8000;
        send_frame();
        collect(1'b0, 1'b0);
        tests_run++;
        if (cap_gain[241] !== 16'd455 || cap_gain[276] !== 16'd16384
            || cap_gain[312] !== 16'h8000 || cap_gain[356] !== 16'd16384
            || cap_gain[399] !== 16'd372) begin
            tests_failed++;
            $display("FAIL ramp_a: %0d %0d %0d %0d %0d, want 455 16384 32768 16384 372",
                     cap_gain[241], cap_gain[276], cap_gain[312], cap_gain[356], cap_gain[399]);
        end
        ref_g[20] = 16'h0;
        ref_g[21] = 16'h8000;
        send_frame();
        collect(1'b0, 1'b0);
        tests_run++;
        if (cap_gain[312] !== 16'd0 || cap_gain[356] !== 16'd16384
            || cap_gain[399] !== 16'd32395 || cap_gain[400] !== 16'd0) begin
            tests_failed++;
            $display("FAIL ramp_b: %0d %0d %0d %0d, want 0 16384 32395 0",
                     cap_gain[312], cap_gain[356], cap_gain[399], cap_gain[400]);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 51; f++) begin
            for (int k = 0; k < NB; k++)
                ref_g[k] = (f == 50) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            send_frame();
            collect(1'b0, 1'b0);
            tests_run++;
            if (cap_n != FS || frame_errs() != 0) begin
                tests_failed++;
                $display("FAIL random_frame%0d: beats=%0d bad bin %0d gain=%h, want 481 beats gain=%h",
                         f, cap_n, bad_k, (bad_k >= 0) ? cap_gain[bad_k] : 16'h0,
                         (bad_k >= 0) ? 16'(ref_gain(bad_k)) : 16'h0);
            end
        end
    endtask

    task automatic test_stall();
        int diff;
        for (int k = 0; k < NB; k++) ref_g[k] = 16'($urandom_range(0, 65535));
        send_frame();
        collect(1'b0, 1'b0);
        for (int k = 0; k < FS; k++) save_gain[k] = cap_gain[k];
        send_frame();
        collect(1'b1, 1'b0);
        diff = 0;
        for (int k = 0; k < FS; k++) if (cap_gain[k] !== save_gain[k]) diff++;
        tests_run++;
        if (cap_n != FS || timed_out != 0) begin
            tests_failed++;
            $display("FAIL stall_count: beats=%0d, want 481", cap_n);
        end
        tests_run++;
        if (stall_viol != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: %0d unstable stalled cycles, want 0", stall_viol);
        end
        tests_run++;
        if (diff != 0 || frame_errs() != 0) begin
            tests_failed++;
            $display("FAIL stall_seq: %0d bins differ from ready=1 run, want 0", diff);
        end
    endtask

    task automatic test_busy_ignore();
        for (int k = 0; k < NB; k++) ref_g[k] = 16'($urandom_range(0, 65535));
        send_frame();
        collect(1'b0, 1'b1);
        tests_run++;
        if (busy_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ready: in_ready=%b mid-frame, want 0", busy_ready);
        end
        tests_run++;
        if (cap_n != FS || frame_errs() != 0) begin
            tests_failed++;
            $display("FAIL busy_frame: beats=%0d bad bin %0d, want 481 beats no bad bin", cap_n, bad_k);
        end
        tests_run++;
        if (post_ready !== 1'b1 || post_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_idle: in_ready=%b out_valid=%b, want 1/0", post_ready, post_valid);
        end
    endtask

    task automatic test_mid_reset();
        bit hit;
        for (int k = 0; k < NB; k++) ref_g[k] = 16'($urandom_range(0, 65535));
        send_frame();
        hit = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1 && out_index === 9'd150) begin
                hit = 1;
                break;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL midrst_reach: bin 150 never seen, want seen");
        end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 9'd0
            || out_last !== 1'b0 || out_gain !== 16'h0) begin
            tests_failed++;
            $display("FAIL midrst_state: valid=%b ready=%b idx=%0d last=%b gain=%h, want 0/1/0/0/0",
                     out_valid, in_ready, out_index, out_last, out_gain);
        end
        for (int k = 0; k < NB; k++) ref_g[k] = 16'($urandom_range(0, 65535));
        send_frame();
        collect(1'b0, 1'b0);
        tests_run++;
        if (first_valid !== 2 || cap_n != FS || frame_errs() != 0) begin
            tests_failed++;
            $display("FAIL midrst_frame: latency=%0d beats=%0d bad bin %0d, want 2/481/none",
                     first_valid, cap_n, bad_k);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_ramp();
        test_random();
        test_stall();
        test_busy_ignore();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
